// File: rtl/simon_pkg.sv
// Shared Simon game definitions: controller state set, mode LED codes and
// read-address select codes, used by both the controller and the datapath.
// Pure declarations; no logic, no latency, no flow control.
package simon_pkg;

    typedef enum logic [1:0] {
        ST_INPUT    = 2'd0,
        ST_PLAYBACK = 2'd1,
        ST_REPEAT   = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [2:0] LED_INPUT    = 3'b001;
    localparam logic [2:0] LED_PLAYBACK = 3'b010;
    localparam logic [2:0] LED_REPEAT   = 3'b100;
    localparam logic [2:0] LED_DONE     = 3'b111;

    localparam logic [1:0] SEL_PLAYBACK = 2'b00;
    localparam logic [1:0] SEL_REPEAT   = 2'b01;
    localparam logic [1:0] SEL_DONE     = 2'b10;

    // Mode LED code shown for each controller state.
    function automatic logic [2:0] leds_of(input state_t s);
        case (s)
            ST_INPUT:    return LED_INPUT;
            ST_PLAYBACK: return LED_PLAYBACK;
            ST_REPEAT:   return LED_REPEAT;
            ST_DONE:     return LED_DONE;
            default:     return LED_INPUT;
        endcase
    endfunction

    // Memory read-address source for each state; INPUT shares the playback
    // address so the freshly written entry is what the datapath sees.
    function automatic logic [1:0] sel_of(input state_t s);
        case (s)
            ST_INPUT:    return SEL_PLAYBACK;
            ST_PLAYBACK: return SEL_PLAYBACK;
            ST_REPEAT:   return SEL_REPEAT;
            ST_DONE:     return SEL_DONE;
            default:     return SEL_PLAYBACK;
        endcase
    endfunction

endpackage

// File: rtl/simon_control_if.sv
// Controller <-> datapath bundle: player button and datapath status in,
// state decode and one-cycle step strobes out.
// Wires only; no latency, no backpressure.
interface simon_control_if;

    logic       advance;
    logic       is_legal;
    logic       play_gt_count;
    logic       repeat_eq_play;
    logic       input_eq_pattern;

    logic [1:0] select;
    logic [2:0] mode_leds;
    logic       clrcount;
    logic       w_en;
    logic       play_inc;
    logic       rep_inc;
    logic       done_inc;

    // Controller side.
    modport master (
        input  advance, is_legal, play_gt_count, repeat_eq_play, input_eq_pattern,
        output select, mode_leds, clrcount, w_en, play_inc, rep_inc, done_inc
    );

    // Datapath / board side.
    modport slave (
        output advance, is_legal, play_gt_count, repeat_eq_play, input_eq_pattern,
        input  select, mode_leds, clrcount, w_en, play_inc, rep_inc, done_inc
    );

endinterface

// File: rtl/simon_step_timer.sv
// Playback step timer: free-runs 0..STEP_CYCLES-1 while enabled, pulses expire on the last count.
// Latency: expire is combinational from the count; the count restarts at 0 the edge after expire.
// No backpressure: restart holds the count at 0 and masks expire.
module simon_step_timer #(
    parameter int STEP_CYCLES = 16,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count step cycles; wrap after the last one, hold at zero when restarted.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire = !restart && (cnt == LAST);

endmodule

// File: rtl/simon_control.sv
// Simon game controller: Moore FSM (INPUT/PLAYBACK/REPEAT/DONE) driving datapath step strobes.
// Latency: strobes are zero-cycle from adv_pulse/step event; state changes on the next edge.
// No backpressure: the player button is edge-detected; one press is one event.
// Build option: define SIMON_PLAYBACK_TIMER_EN to pace PLAYBACK with simon_step_timer
// (STEP_CYCLES per step) instead of the player button.
module simon_control
    import simon_pkg::*;
#(
    parameter int STEP_CYCLES = 16,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             rst,
    simon_control_if.master  bus
);

    state_t state;
    logic   adv_s;      // advance as sampled on the last edge
    logic   adv_h;      // advance as sampled one edge earlier
    logic   first_q;    // set by reset, marks the first cycle after release
    logic   adv_pulse;
    logic   step_evt;
    logic   run;

    // Button history; reset to 1 so a button held through reset gives no pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            adv_s <= 1'b1;
            adv_h <= 1'b1;
        end else begin
            adv_s <= bus.advance;
            adv_h <= adv_s;
        end
    end

    assign adv_pulse = adv_s && !adv_h;

    // Remember that reset was active so clrcount fires once on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_q <= 1'b1;
        end else begin
            first_q <= 1'b0;
        end
    end

`ifdef SIMON_PLAYBACK_TIMER_EN
    logic tmr_expire;

    simon_step_timer #(
        .STEP_CYCLES (STEP_CYCLES),
        .CNT_W       (CNT_W)
    ) u_step_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (state != ST_PLAYBACK),
        .expire  (tmr_expire)
    );

    // Button presses during playback are ignored; only the timer steps it.
    assign step_evt = tmr_expire;
`else
    localparam int unused_step_cfg = STEP_CYCLES + CNT_W;

    assign step_evt = adv_pulse;
`endif

    // Game state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INPUT;
        end else begin
            case (state)
                ST_INPUT: begin
                    if (adv_pulse && bus.is_legal) begin
                        state <= ST_PLAYBACK;
                    end
                end
                ST_PLAYBACK: begin
                    if (step_evt && bus.play_gt_count) begin
                        state <= ST_REPEAT;
                    end
                end
                ST_REPEAT: begin
                    if (adv_pulse) begin
                        if (!bus.input_eq_pattern) begin
                            state <= ST_DONE;
                        end else if (bus.repeat_eq_play) begin
                            state <= ST_INPUT;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_INPUT;
                end
            endcase
        end
    end

    assign run           = !rst;
    assign bus.mode_leds = leds_of(state);
    assign bus.select    = sel_of(state);
    assign bus.clrcount  = first_q && run;

    // Step strobes: each is qualified by a distinct state, so at most one is high.
    assign bus.w_en     = run && (state == ST_INPUT)    && adv_pulse && bus.is_legal;
    assign bus.play_inc = run && (state == ST_PLAYBACK) && step_evt  && !bus.play_gt_count;
    assign bus.rep_inc  = run && (state == ST_REPEAT)   && adv_pulse &&
                          bus.input_eq_pattern && !bus.repeat_eq_play;
    assign bus.done_inc = run && (state == ST_DONE)     && adv_pulse;

endmodule

// File: tb/tb_simon_control.sv
// Bench for simon_control: directed vector tables, hand-written corner sequences,
// then randomized play against a rule-level reference model.
// Works in both builds (with and without SIMON_PLAYBACK_TIMER_EN), STEP_CYCLES=4.
module tb_simon_control;

    localparam int STEP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    simon_control_if bus_if ();

    simon_control #(
        .STEP_CYCLES (STEP),
        .CNT_W       (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, a, l, p, q, e;   // rst, advance, is_legal, play_gt_count, repeat_eq_play, input_eq_pattern
        logic [2:0] mode;
        logic [1:0] sel;
        logic [4:0] stb;                // {clrcount, w_en, play_inc, rep_inc, done_inc}
    } vec_t;

    function automatic vec_t mk(input logic r, a, l, p, q, e,
                                input logic [2:0] mode, input logic [1:0] sel,
                                input logic [4:0] stb);
        vec_t v;
        v.r = r; v.a = a; v.l = l; v.p = p; v.q = q; v.e = e;
        v.mode = mode; v.sel = sel; v.stb = stb;
        return v;
    endfunction

    function automatic logic [4:0] obs_stb();
        return {bus_if.clrcount, bus_if.w_en, bus_if.play_inc, bus_if.rep_inc, bus_if.done_inc};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive just after the rising edge, return at the falling edge.
    task automatic cyc(input logic r, a, l, p, q, e);
        @(posedge clk);
        #1;
        rst                     = r;
        bus_if.advance          = a;
        bus_if.is_legal         = l;
        bus_if.play_gt_count    = p;
        bus_if.repeat_eq_play   = q;
        bus_if.input_eq_pattern = e;
        @(negedge clk);
    endtask

    task automatic apply(input string nm, input int idx, input vec_t v);
        cyc(v.r, v.a, v.l, v.p, v.q, v.e);
        chk($sformatf("%s[%0d].mode", nm, idx), 32'(bus_if.mode_leds), 32'(v.mode));
        chk($sformatf("%s[%0d].sel", nm, idx), 32'(bus_if.select), 32'(v.sel));
        chk($sformatf("%s[%0d].stb", nm, idx), 32'(obs_stb()), 32'(v.stb));
    endtask

    // From INPUT: legal press, then run playback until REPEAT is reached.
    task automatic to_repeat();
        cyc(0, 1, 1, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 1);
        chk("enter.w_en", 32'(obs_stb()), 32'b01000);
        cyc(0, 0, 0, 0, 0, 1);
        chk("enter.mode_pb", 32'(bus_if.mode_leds), 32'b010);
`ifdef SIMON_PLAYBACK_TIMER_EN
        for (int k = 1; k < STEP; k++) begin
            cyc(0, 0, 0, 1, 0, 1);
        end
        chk("enter.last_step_no_inc", 32'(obs_stb()), 32'b00000);
`else
        cyc(0, 1, 0, 1, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        chk("enter.last_step_no_inc", 32'(obs_stb()), 32'b00000);
`endif
        cyc(0, 0, 0, 0, 0, 1);
        chk("enter.mode_rep", 32'(bus_if.mode_leds), 32'b100);
    endtask

    vec_t ta[8];
    vec_t tp[5];
    vec_t tb[9];

    // Reference model state, in game terms (mode LED code, button history, playback age).
    int   m_mode;
    logic m_s, m_h, m_clr;
    int   pb_age;

    initial begin
        bus_if.advance          = 1'b0;
        bus_if.is_legal         = 1'b0;
        bus_if.play_gt_count    = 1'b0;
        bus_if.repeat_eq_play   = 1'b0;
        bus_if.input_eq_pattern = 1'b0;

        // Reset, release, illegal press, legal press.
        ta[0] = mk(1, 0, 0, 0, 0, 0, 3'b001, 2'b00, 5'b00000);
        ta[1] = mk(0, 0, 0, 0, 0, 0, 3'b001, 2'b00, 5'b10000);
        ta[2] = mk(0, 1, 0, 0, 0, 0, 3'b001, 2'b00, 5'b00000);
        ta[3] = mk(0, 0, 0, 0, 0, 0, 3'b001, 2'b00, 5'b00000);
        ta[4] = mk(0, 0, 0, 0, 0, 0, 3'b001, 2'b00, 5'b00000);
        ta[5] = mk(0, 1, 1, 0, 0, 0, 3'b001, 2'b00, 5'b00000);
        ta[6] = mk(0, 0, 1, 0, 0, 0, 3'b001, 2'b00, 5'b01000);
        ta[7] = mk(0, 0, 1, 0, 0, 0, 3'b010, 2'b00, 5'b00000);

        // Button-paced playback: one step, then last step into REPEAT.
        tp[0] = mk(0, 1, 0, 0, 0, 0, 3'b010, 2'b00, 5'b00000);
        tp[1] = mk(0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 5'b00100);
        tp[2] = mk(0, 1, 0, 1, 0, 0, 3'b010, 2'b00, 5'b00000);
        tp[3] = mk(0, 0, 0, 1, 0, 0, 3'b010, 2'b00, 5'b00000);
        tp[4] = mk(0, 0, 0, 0, 0, 1, 3'b100, 2'b01, 5'b00000);

        // REPEAT: three correct presses, then the final one back to INPUT.
        tb[0] = mk(0, 1, 0, 0, 0, 1, 3'b100, 2'b01, 5'b00000);
        tb[1] = mk(0, 0, 0, 0, 0, 1, 3'b100, 2'b01, 5'b00010);
        tb[2] = mk(0, 1, 0, 0, 0, 1, 3'b100, 2'b01, 5'b00000);
        tb[3] = mk(0, 0, 0, 0, 0, 1, 3'b100, 2'b01, 5'b00010);
        tb[4] = mk(0, 1, 0, 0, 0, 1, 3'b100, 2'b01, 5'b00000);
        tb[5] = mk(0, 0, 0, 0, 0, 1, 3'b100, 2'b01, 5'b00010);
        tb[6] = mk(0, 1, 0, 0, 1, 1, 3'b100, 2'b01, 5'b00000);
        tb[7] = mk(0, 0, 0, 0, 1, 1, 3'b100, 2'b01, 5'b00000);
        tb[8] = mk(0, 0, 0, 0, 0, 0, 3'b001, 2'b00, 5'b00000);

        repeat (2) @(posedge clk);

        for (int i = 0; i < 8; i++) apply("input", i, ta[i]);

`ifdef SIMON_PLAYBACK_TIMER_EN
        // Timer-paced playback; button presses in the first cycles are ignored.
        for (int k = 1; k <= 15; k++) begin
            logic a;
            logic exp_inc;
            a = (k <= 10) ? logic'($urandom_range(0, 1)) : 1'b0;
            exp_inc = ((k % STEP) == STEP - 1) && (k < 12);
            cyc(0, a, 0, (k >= 12), 0, 0);
            chk($sformatf("timer[%0d].stb", k), 32'(obs_stb()), {29'd0, exp_inc, 2'b00});
            chk($sformatf("timer[%0d].mode", k), 32'(bus_if.mode_leds), 32'b010);
        end
        cyc(0, 0, 0, 0, 0, 1);
        chk("timer.enter_rep_mode", 32'(bus_if.mode_leds), 32'b100);
        chk("timer.enter_rep_sel", 32'(bus_if.select), 32'b01);
`else
        for (int i = 0; i < 5; i++) apply("play", i, tp[i]);
`endif

        for (int i = 0; i < 9; i++) apply("repeat", i, tb[i]);

        // Wrong entry in REPEAT -> DONE; a long held press gives one done_inc.
        to_repeat();
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("fail.no_rep_inc", 32'(obs_stb()), 32'b00000);
        cyc(0, 0, 0, 0, 0, 0);
        chk("done.mode", 32'(bus_if.mode_leds), 32'b111);
        chk("done.sel", 32'(bus_if.select), 32'b10);
        begin
            int dcnt;
            dcnt = 0;
            for (int k = 0; k < 10; k++) begin
                cyc(0, 1, 0, 0, 0, 0);
                dcnt += int'(bus_if.done_inc);
            end
            for (int k = 0; k < 3; k++) begin
                cyc(0, 0, 0, 0, 0, 0);
                dcnt += int'(bus_if.done_inc);
            end
            chk("done.held_press_count", 32'(dcnt), 32'd1);
        end
        chk("done.persist", 32'(bus_if.mode_leds), 32'b111);

        // Reset pulse while in DONE.
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_done.stb_in_rst", 32'(obs_stb()), 32'b00000);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst_done.mode", 32'(bus_if.mode_leds), 32'b001);
        chk("rst_done.clr", 32'(obs_stb()), 32'b10000);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst_done.clr_once", 32'(obs_stb()), 32'b00000);

        // Randomized play against the rule-level model.
        m_mode = 1; m_s = 1'b0; m_h = 1'b0; m_clr = 1'b0; pb_age = 0;
        for (int n = 0; n < 1500; n++) begin
            logic r, a, l, p, q, e;
            logic pulse, step;
            logic wen, pinc, rinc, dinc;
            int   nxt;
            logic [1:0] esel;
            r = ($urandom_range(0, 59) == 0);
            a = logic'($urandom_range(0, 1));
            l = logic'($urandom_range(0, 1));
            p = ($urandom_range(0, 3) == 0);
            q = ($urandom_range(0, 3) == 0);
            e = ($urandom_range(0, 19) < 17);
            cyc(r, a, l, p, q, e);

            pulse = m_s && !m_h;
`ifdef SIMON_PLAYBACK_TIMER_EN
            step = ((pb_age % STEP) == STEP - 1);
`else
            step = pulse;
`endif
            wen = 0; pinc = 0; rinc = 0; dinc = 0;
            nxt = m_mode;
            if (!r) begin
                if (m_mode == 1) begin
                    wen = pulse && l;
                    if (wen) nxt = 2;
                end else if (m_mode == 2) begin
                    if (step && p) nxt = 4;
                    else pinc = step;
                end else if (m_mode == 4) begin
                    if (pulse) begin
                        if (!e) nxt = 7;
                        else if (q) nxt = 1;
                        else rinc = 1;
                    end
                end else begin
                    dinc = pulse;
                end
            end
            esel = (m_mode == 4) ? 2'b01 : (m_mode == 7) ? 2'b10 : 2'b00;
            chk($sformatf("rand[%0d].mode", n), 32'(bus_if.mode_leds), 32'(m_mode));
            chk($sformatf("rand[%0d].sel", n), 32'(bus_if.select), 32'(esel));
            chk($sformatf("rand[%0d].stb", n), 32'(obs_stb()),
                {27'd0, m_clr && !r, wen, pinc, rinc, dinc});

            if (r) begin
                m_mode = 1; m_s = 1'b1; m_h = 1'b1; m_clr = 1'b1; pb_age = 0;
            end else begin
                pb_age = (m_mode == 2 && nxt == 2) ? pb_age + 1 : 0;
                m_mode = nxt;
                m_h = m_s;
                m_s = a;
                m_clr = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/simon_control.md
SIMON_CONTROL -- requirements
Module: simon_control

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 16, playback step hold time in clk cycles (timer build only).
REQ-002 SHALL have parameter CNT_W, default 6, width of the internal 0..63 round counters.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 advance  input  1  player step button, level; internal rising-edge detect gives adv_pulse.
REQ-006 is_legal, play_gt_count, repeat_eq_play, input_eq_pattern  input  1 each  status from SimonDatapath.
REQ-007 select  output  2  read-address mux: 00 playback, 01 repeat, 10 done.
REQ-008 mode_leds  output  3  state code: INPUT 001, PLAYBACK 010, REPEAT 100, DONE 111.
REQ-009 clrcount  output  1  clear datapath round count; w_en  output  1  write pattern to memory.
REQ-010 play_inc, rep_inc, done_inc  output  1 each  one-cycle step strobes to datapath counters.

Function
REQ-011 SHALL implement a Moore FSM with states INPUT, PLAYBACK, REPEAT, DONE; mode_leds and select SHALL decode from the state register only (INPUT/PLAYBACK select 00, REPEAT 01, DONE 10).
REQ-012 adv_pulse SHALL be high for exactly one cycle, the cycle after advance is first sampled 1 following a sampled 0; holding advance high yields one pulse.
REQ-013 INPUT: adv_pulse with is_legal=1 SHALL assert w_en in that same cycle and move to PLAYBACK next edge; with is_legal=0 no w_en, stay INPUT.
REQ-014 PLAYBACK: each step event SHALL assert play_inc for one cycle; if play_gt_count=1 at the step event, SHALL go to REPEAT instead, with no play_inc.
REQ-015 REPEAT: on adv_pulse, input_eq_pattern=0 SHALL go to DONE; else repeat_eq_play=1 SHALL go to INPUT; else assert rep_inc, stay REPEAT.
REQ-016 DONE: each adv_pulse SHALL assert done_inc; DONE SHALL persist until rst.
REQ-017 clrcount SHALL be high exactly one cycle: the first cycle after rst deasserts; never on REPEAT-to-INPUT.
REQ-018 w_en, play_inc, rep_inc, done_inc SHALL be mutually exclusive and never high together in one cycle.
REQ-019 Strobes SHALL depend only on current state plus current-cycle inputs; latency from adv_pulse to strobe is zero cycles, to state change one edge.
REQ-020 advance edges arriving while in PLAYBACK SHALL be ignored in the timer build.

Reset
REQ-021 While rst=1: state INPUT, mode_leds 001, select 00, all strobes 0, clrcount 0, edge-detect history 1 (so a held button yields no pulse after reset), timer 0.
REQ-022 rst asserted in any state mid-operation SHALL override all transitions that edge.

Configuration
REQ-023 Macro SIMON_PLAYBACK_TIMER_EN defined: PLAYBACK step event = internal timer reaching STEP_CYCLES-1, timer restarts at 0 on entry to PLAYBACK and after each step.
REQ-024 Macro undefined: PLAYBACK step event = adv_pulse; no timer logic; STEP_CYCLES unused.

Structure
REQ-025 Package simon_pkg SHALL hold the state enum, mode_leds codes and select codes, shared with SimonDatapath.
REQ-026 One sub-module simon_step_timer (counter, STEP_CYCLES, restart, expire pulse), instantiated only under SIMON_PLAYBACK_TIMER_EN.

Verification
REQ-027 Reset release with advance low -> clrcount=1 one cycle, mode_leds=001, no strobes.
REQ-028 INPUT, is_legal=0, advance pulse -> w_en stays 0, mode_leds 001; repeat with is_legal=1 -> w_en one cycle, next cycle mode_leds 010.
REQ-029 Timer build, STEP_CYCLES=4, play_gt_count=0 -> play_inc every 4th cycle; set play_gt_count=1 -> next expiry enters REPEAT (100), no play_inc.
REQ-030 REPEAT, input_eq_pattern=1, repeat_eq_play=0, 3 pulses -> 3 rep_inc; then repeat_eq_play=1 pulse -> INPUT, no clrcount.
REQ-031 REPEAT, input_eq_pattern=0 pulse -> DONE (111, select 10); advance held high 10 cycles -> exactly one done_inc.
REQ-032 rst pulsed in DONE -> INPUT next edge, clrcount one cycle after release.
